// File: rtl/ultrasonic_trigger.sv
// Ranging sequencer for the ultrasonic sensor.
// It fires a fixed-width trigger pulse and clears the echo-timing block with trig_start.
// It then waits for an echo or a timeout and latches the distance count.
// A hold-off follows before the next shot, in one-shot (start) or free-running (enable) mode.
`default_nettype none

module ultrasonic_trigger #(
   parameter int TICK_DIV   = 100,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int HOLDOFF_US = 60000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       start,
   input  logic       echo_done,
   input  logic [9:0] echo_value,
   output logic       trig,
   output logic       trig_start,
   output logic       busy,
   output logic       result_valid,
   output logic [9:0] result,
   output logic       timeout
);

   // Prescaler width is sized so the counter can hold TICK_DIV-1.
   // Each phase ends on the tick that completes its last microsecond.
   // That tick is the one where the us counter still reads N-1.
   localparam int                    PRESCALE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESCALE_W-1:0] PRESCALE_END = PRESCALE_W'(TICK_DIV - 1);
   localparam logic [15:0]           TRIG_END     = 16'(TRIG_US - 1);
   localparam logic [15:0]           TIMEOUT_END  = 16'(TIMEOUT_US - 1);
   localparam logic [15:0]           HOLDOFF_END  = 16'(HOLDOFF_US - 1);
   localparam logic [9:0]            TIMEOUT_CODE = 10'h3FF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT,
      ST_HOLDOFF
   } stateT;

   stateT                 state;
   stateT                 stateNext;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] prescaleNext;
   logic [15:0]           usCount;
   logic [15:0]           usCountNext;
   logic                  tick;
   logic                  trigNext;
   logic                  trigStartNext;
   logic                  busyNext;
   logic                  resultValidNext;
   logic [9:0]            resultNext;
   logic                  timeoutNext;

   // The microsecond tick fires on the last clock of each prescaler period.
   // It is only meaningful while a timed phase is running.
   always_comb begin
      tick = (prescale == PRESCALE_END);
   end

   // Next-state and next-output logic.
   // Every output is the registered copy of the value computed here.
   // That way trig and trig_start are already visible in the first cycle of a new state.
   // A state change always restarts both timing counters.
   // Each phase therefore measures its own length from zero.
   always_comb begin
      stateNext       = state;
      prescaleNext    = prescale + PRESCALE_W'(1);
      usCountNext     = usCount;
      resultValidNext = 1'b0;
      resultNext      = result;
      timeoutNext     = timeout;

      if (tick) begin
         prescaleNext = '0;
         usCountNext  = usCount + 16'd1;
      end

      case (state)
         ST_IDLE: begin
            prescaleNext = '0;
            usCountNext  = '0;
            if (start || enable) begin
               stateNext = ST_TRIG;
            end
         end

         ST_TRIG: begin
            if (tick && (usCount == TRIG_END)) begin
               stateNext = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // echo_done is checked first, so it wins a tie with the timeout tick.
            if (echo_done) begin
               resultNext      = echo_value;
               timeoutNext     = 1'b0;
               resultValidNext = 1'b1;
               stateNext       = ST_HOLDOFF;
            end else if (tick && (usCount == TIMEOUT_END)) begin
               resultNext      = TIMEOUT_CODE;
               timeoutNext     = 1'b1;
               resultValidNext = 1'b1;
               stateNext       = ST_HOLDOFF;
            end
         end

         ST_HOLDOFF: begin
            // start is deliberately ignored here; only enable re-arms directly.
            if (tick && (usCount == HOLDOFF_END)) begin
               stateNext = enable ? ST_TRIG : ST_IDLE;
            end
         end

         default: begin
            stateNext = ST_IDLE;
         end
      endcase

      if (stateNext != state) begin
         prescaleNext = '0;
         usCountNext  = '0;
      end

      trigNext      = (stateNext == ST_TRIG);
      trigStartNext = (stateNext == ST_TRIG) && (state != ST_TRIG);
      busyNext      = (stateNext != ST_IDLE);
   end

   // State register and timing counters.
   // Reset overrides everything and drops the sequencer straight back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         prescale <= '0;
         usCount  <= '0;
      end else begin
         state    <= stateNext;
         prescale <= prescaleNext;
         usCount  <= usCountNext;
      end
   end

   // Output registers.
   // A reset in mid-measurement pulls trig low on the very next edge.
   // It also clears the stored result without raising result_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         trig         <= 1'b0;
         trig_start   <= 1'b0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result       <= '0;
         timeout      <= 1'b0;
      end else begin
         trig         <= trigNext;
         trig_start   <= trigStartNext;
         busy         <= busyNext;
         result_valid <= resultValidNext;
         result       <= resultNext;
         timeout      <= timeoutNext;
      end
   end

endmodule

`default_nettype wire
